cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
Synthesisable run/dump controller for the single-cycle CPU. On a start request it holds the CPU in reset, lets it run for a programmed number of cycles or until it halts, then freezes it. It then reads a configurable window of the register file through the debug read port and streams the values out over a valid/ready interface. It sits between the CPU top and a host or bench-side consumer, and replaces fixed-count run-and-print sequencing.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register-file address width
DUMP_BASE, 0, first register index dumped
DUMP_COUNT, 12, number of registers dumped (1..2^ADDR_W-DUMP_BASE)
CNT_W, 16, run-length and cycle-counter width
RST_CYCLES, 1, cycles CPU reset is held low (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
start_i  in  1  start pulse; accepted only in IDLE or DONE
run_len_i  in  CNT_W  CPU cycles to run; sampled when start_i is accepted
halt_i  in  1  CPU halt indication; ends RUN early
cpu_rst_n_o  out  1  active-low reset to the CPU
cpu_en_o  out  1  CPU clock-enable; high only in RUN
dbg_addr_o  out  ADDR_W  register-file debug read address
dbg_data_i  in  DATA_W  register-file asynchronous read data
dump_valid_o  out  1  dump word valid
dump_ready_i  in  1  consumer ready
dump_idx_o  out  ADDR_W  register index of dump word
dump_data_o  out  DATA_W  register value
cycle_cnt_o  out  CNT_W  CPU cycles executed in the last or current run
stop_reason_o  out  2  0 none, 1 count reached, 2 halt
busy_o  out  1  high in RESET, RUN, LOAD, SEND
done_o  out  1  high in DONE

Behaviour:
- States: IDLE, RESET, RUN, LOAD, SEND, DONE.
- Values while rst_i is low (asynchronous): state IDLE, cpu_rst_n_o=0, cpu_en_o=0, dump_valid_o=0, dump_idx_o=0, dump_data_o=0, dbg_addr_o=0, cycle_cnt_o=0, stop_reason_o=0, busy_o=0, done_o=0.
- Reset asserted mid-operation aborts immediately to IDLE. A pending dump word is dropped.
- IDLE/DONE + start_i: latch run_len_i, clear cycle_cnt_o and stop_reason_o, then go to RESET.
- RESET: cpu_rst_n_o=0 for exactly RST_CYCLES cycles, then go to RUN. cpu_rst_n_o=1 in every other state except IDLE.
- RUN: cpu_en_o=1, and cycle_cnt_o increments each cycle.
  - Leave RUN at the end of the cycle where cycle_cnt_o+1 == latched length (stop_reason 1), or when halt_i=1 (stop_reason 2).
  - If both happen in the same cycle, halt wins: stop_reason 2, and the count still increments for that cycle.
  - A latched length of 0 skips RUN: RESET goes directly to LOAD with stop_reason 1 and cycle_cnt_o=0.
  - halt_i is ignored outside RUN.
- LOAD: dbg_addr_o = DUMP_BASE+k. Capture dbg_data_i into dump_data_o and set dump_idx_o=DUMP_BASE+k, then go to SEND. Latency is one cycle per word before valid.
- SEND: dump_valid_o=1, with dump_idx_o and dump_data_o held stable until dump_ready_i=1.
  - On a handshake, go to LOAD with k+1, or to DONE after word DUMP_COUNT-1.
  - dump_valid_o deasserts in the cycle after the handshake.
  - Maximum throughput is one word per 2 cycles.
- DONE: done_o=1 and cpu_en_o=0. Register contents, cycle_cnt_o and stop_reason_o are preserved. start_i restarts from RESET.
- start_i is ignored while busy_o=1.
- cycle_cnt_o never wraps, because the latched length bounds it.

Decomposition:
- Shared package: state encoding constants, stop-reason constants (STOP_NONE=0, STOP_COUNT=1, STOP_HALT=2).
- One natural sub-module, run_cycle_counter: loadable down/up counter with terminal-count flag. Everything else is inline.

Test Plan:
- start, run_len=5, halt_i=0 -> cpu_rst_n_o low 1 cycle, cpu_en_o high exactly 5 cycles, cycle_cnt_o=5, stop_reason_o=1, then 12 words idx 0..11 with register values, then done_o=1.
- run_len=100, halt_i pulsed in RUN cycle 7 -> cpu_en_o drops after 7 cycles, cycle_cnt_o=7, stop_reason_o=2.
- halt_i coinciding with the final count (run_len=4, halt in cycle 4) -> cycle_cnt_o=4, stop_reason_o=2.
- dump_ready_i held low 10 cycles on word 3 -> dump_valid_o stays high, idx=3 and data stable throughout. No word is skipped or duplicated.
- run_len=0 -> no RUN cycles, dump starts immediately, cycle_cnt_o=0, stop_reason_o=1. start_i during SEND has no effect.
- rst_i low during SEND of word 6 -> all outputs reach reset values asynchronously. A new start performs a full fresh sequence from idx 0.

Source files
------------

// File: rtl/cpu_run_controller_pkg.sv
// Shared state encoding and stop-reason codes for the CPU run/dump controller.
package cpu_run_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_LOAD  = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] STOP_NONE  = 2'd0;
  localparam logic [1:0] STOP_COUNT = 2'd1;
  localparam logic [1:0] STOP_HALT  = 2'd2;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Register dump stream: valid/ready handshake carrying register index and value.
interface cpu_run_controller_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [ADDR_W-1:0] dump_idx_o;
  logic [DATA_W-1:0] dump_data_o;

  modport master (output dump_valid_o, output dump_idx_o, output dump_data_o,
                  input  dump_ready_i);

  modport slave  (input  dump_valid_o, input  dump_idx_o, input  dump_data_o,
                  output dump_ready_i);

endinterface

// File: rtl/cpu_run_controller_run_cycle_counter.sv
// Run-length tracker: the down-counter holds the cycles still to run and
// drives the terminal flags; the up-counter is the visible cycle count.
module run_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             zero
);

  logic [CNT_W-1:0] remain;

  // Load on start, then count down remaining / count up executed per RUN cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      remain <= '0;
      count  <= '0;
    end else if (load) begin
      remain <= len;
      count  <= '0;
    end else if (step) begin
      remain <= remain - 1'b1;
      count  <= count + 1'b1;
    end
  end

  // last: the current RUN cycle is the final one; zero: nothing to run at all.
  assign last = (remain == CNT_W'(1));
  assign zero = (remain == '0);

endmodule

// File: rtl/cpu_run_controller.sv
// Runs the CPU for a programmed length (or until halt), freezes it, then
// streams a window of the register file out over the dump interface.
//
// state | meaning
// IDLE  | waiting for start, CPU held in reset
// RESET | CPU reset held low for RST_CYCLES cycles
// RUN   | CPU clock enabled, cycles counted
// LOAD  | debug port addressed, register value captured
// SEND  | dump word offered until accepted
// DONE  | results held, CPU frozen, restart allowed
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_COUNT = 12,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  run_len_i,
  input  logic              halt_i,
  output logic              cpu_rst_n_o,
  output logic              cpu_en_o,
  output logic [ADDR_W-1:0] dbg_addr_o,
  input  logic [DATA_W-1:0] dbg_data_i,
  cpu_run_controller_if.master dump,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [1:0]        stop_reason_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(DUMP_BASE);
  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(DUMP_COUNT - 1);

  state_t            state, next_state;
  logic [RC_W-1:0]   rst_cnt;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] dump_idx_q;
  logic [DATA_W-1:0] dump_data_q;
  logic [1:0]        stop_q, stop_nxt;
  logic              cnt_load, cnt_step, cnt_last, cnt_zero;
  logic              stop_wr, k_clr, k_inc, capture, rc_clr, dump_valid;

  run_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (cnt_load),
    .step  (cnt_step),
    .len   (run_len_i),
    .count (cycle_cnt_o),
    .last  (cnt_last),
    .zero  (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode and state-derived outputs/controls.
  always_comb begin
    next_state  = state;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;
    stop_wr     = 1'b0;
    stop_nxt    = STOP_NONE;
    k_clr       = 1'b0;
    k_inc       = 1'b0;
    capture     = 1'b0;
    rc_clr      = 1'b0;
    dump_valid  = 1'b0;
    cpu_rst_n_o = 1'b1;
    cpu_en_o    = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    dbg_addr_o  = '0;
    case (state)
      S_IDLE, S_DONE: begin
        cpu_rst_n_o = (state == S_DONE);
        done_o      = (state == S_DONE);
        if (start_i) begin
          next_state = S_RESET;
          cnt_load   = 1'b1;
          stop_wr    = 1'b1;
          rc_clr     = 1'b1;
        end
      end
      S_RESET: begin
        cpu_rst_n_o = 1'b0;
        busy_o      = 1'b1;
        if (rst_cnt == RC_LAST) begin
          k_clr = 1'b1;
          if (cnt_zero) begin
            next_state = S_LOAD;
            stop_wr    = 1'b1;
            stop_nxt   = STOP_COUNT;
          end else begin
            next_state = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy_o   = 1'b1;
        cpu_en_o = 1'b1;
        cnt_step = 1'b1;
        if (halt_i) begin
          next_state = S_LOAD;
          stop_wr    = 1'b1;
          stop_nxt   = STOP_HALT;
        end else if (cnt_last) begin
          next_state = S_LOAD;
          stop_wr    = 1'b1;
          stop_nxt   = STOP_COUNT;
        end
      end
      S_LOAD: begin
        busy_o     = 1'b1;
        dbg_addr_o = BASE_A + k;
        capture    = 1'b1;
        next_state = S_SEND;
      end
      S_SEND: begin
        busy_o     = 1'b1;
        dump_valid = 1'b1;
        if (dump.dump_ready_i) begin
          if (k == K_LAST) begin
            next_state = S_DONE;
          end else begin
            k_inc      = 1'b1;
            next_state = S_LOAD;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: reset-hold timer, dump index, captured word and stop reason.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_cnt     <= '0;
      k           <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
      stop_q      <= STOP_NONE;
    end else begin
      if (rc_clr)                  rst_cnt <= '0;
      else if (state == S_RESET)   rst_cnt <= rst_cnt + RC_W'(1);
      if (k_clr)                   k <= '0;
      else if (k_inc)              k <= k + 1'b1;
      if (capture) begin
        dump_idx_q  <= BASE_A + k;
        dump_data_q <= dbg_data_i;
      end
      if (stop_wr)                 stop_q <= stop_nxt;
    end
  end

  assign stop_reason_o     = stop_q;
  assign dump.dump_valid_o = dump_valid;
  assign dump.dump_idx_o   = dump_idx_q;
  assign dump.dump_data_o  = dump_data_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for the CPU run/dump controller with a behavioural register file.
module tb_cpu_run_controller;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] run_len_i = '0;
  logic        halt_i = 1'b0;
  logic        cpu_rst_n_o, cpu_en_o, busy_o, done_o;
  logic [4:0]  dbg_addr_o;
  logic [31:0] dbg_data_i;
  logic [15:0] cycle_cnt_o;
  logic [1:0]  stop_reason_o;

  int total = 0;
  int bad = 0;

  int          r_en, r_rstlow, r_words, r_stall_valid, r_unstable, r_fin;
  int          r_early_cnt, r_early_stop;
  logic [4:0]  r_idx [32];
  logic [31:0] r_data [32];

  cpu_run_controller_if #(.DATA_W(32), .ADDR_W(5)) dump_if ();

  cpu_run_controller #(
    .DATA_W(32), .ADDR_W(5), .DUMP_BASE(0), .DUMP_COUNT(12), .CNT_W(16), .RST_CYCLES(1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .run_len_i     (run_len_i),
    .halt_i        (halt_i),
    .cpu_rst_n_o   (cpu_rst_n_o),
    .cpu_en_o      (cpu_en_o),
    .dbg_addr_o    (dbg_addr_o),
    .dbg_data_i    (dbg_data_i),
    .dump          (dump_if),
    .cycle_cnt_o   (cycle_cnt_o),
    .stop_reason_o (stop_reason_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] regval(input logic [4:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  assign dbg_data_i = regval(dbg_addr_o);

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Start one run and follow it to DONE, recording what the DUT did.
  task automatic run_seq(input int len, input int halt_cycle, input int stall_word,
                         input int stall_len, input bit start_in_send);
    int          wait_cnt;
    bit          in_word, did_start;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    r_en = 0; r_rstlow = 0; r_words = 0; r_stall_valid = 0; r_unstable = 0; r_fin = 0;
    wait_cnt = 0; in_word = 0; did_start = 0; h_idx = '0; h_data = '0;
    dump_if.dump_ready_i = 1'b0;
    halt_i = 1'b0;
    run_len_i = 16'(len);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_len_i = 16'hFFFF;
    r_early_cnt = int'(cycle_cnt_o);
    r_early_stop = int'(stop_reason_o);
    for (int c = 0; c < 3000; c++) begin
      if (done_o) begin
        r_fin = 1;
        break;
      end
      start_i = 1'b0;
      if (!cpu_rst_n_o) r_rstlow++;
      if (cpu_en_o) r_en++;
      halt_i = cpu_en_o && (r_en == halt_cycle);
      dump_if.dump_ready_i = 1'b0;
      if (dump_if.dump_valid_o) begin
        if (!in_word) begin
          in_word = 1; h_idx = dump_if.dump_idx_o; h_data = dump_if.dump_data_o; wait_cnt = 0;
        end else if (dump_if.dump_idx_o !== h_idx || dump_if.dump_data_o !== h_data) begin
          r_unstable++;
        end
        if (r_words == stall_word) r_stall_valid++;
        if (start_in_send && !did_start && r_words == 2) begin
          start_i = 1'b1;
          did_start = 1;
        end
        if (r_words == stall_word && wait_cnt < stall_len) begin
          wait_cnt++;
        end else begin
          dump_if.dump_ready_i = 1'b1;
          if (r_words < 32) begin
            r_idx[r_words] = dump_if.dump_idx_o;
            r_data[r_words] = dump_if.dump_data_o;
          end
          r_words++;
          in_word = 0;
        end
      end
      step();
    end
    start_i = 1'b0;
    halt_i = 1'b0;
    dump_if.dump_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    dump_if.dump_ready_i = 1'b0;
    step(); step();
    total++; if (cpu_rst_n_o !== 1'b0) begin bad++; $display("FAIL reset_cpu_rst_n got=%0b exp=0", cpu_rst_n_o); end
    total++; if (cpu_en_o !== 1'b0) begin bad++; $display("FAIL reset_cpu_en got=%0b exp=0", cpu_en_o); end
    total++; if (dump_if.dump_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", dump_if.dump_valid_o); end
    total++; if (dump_if.dump_idx_o !== 5'd0 || dump_if.dump_data_o !== 32'd0) begin bad++; $display("FAIL reset_dump got=%0d/%h exp=0/0", dump_if.dump_idx_o, dump_if.dump_data_o); end
    total++; if (dbg_addr_o !== 5'd0) begin bad++; $display("FAIL reset_dbg_addr got=%0d exp=0", dbg_addr_o); end
    total++; if (cycle_cnt_o !== 16'd0 || stop_reason_o !== 2'd0) begin bad++; $display("FAIL reset_cnt_stop got=%0d/%0d exp=0/0", cycle_cnt_o, stop_reason_o); end
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%0b/%0b exp=0/0", busy_o, done_o); end
    rst_i = 1'b1;
    step(); step();
    total++; if (busy_o !== 1'b0 || cpu_rst_n_o !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy/rst_n got=%0b/%0b exp=0/0", busy_o, cpu_rst_n_o); end
  endtask

  task automatic test_count_run();
    run_seq(5, 0, -1, 0, 0);
    total++; if (r_fin !== 1) begin bad++; $display("FAIL count_timeout got=%0d exp=1", r_fin); end
    total++; if (r_rstlow !== 1) begin bad++; $display("FAIL count_rst_cycles got=%0d exp=1", r_rstlow); end
    total++; if (r_en !== 5) begin bad++; $display("FAIL count_en_cycles got=%0d exp=5", r_en); end
    total++; if (cycle_cnt_o !== 16'd5) begin bad++; $display("FAIL count_cycle_cnt got=%0d exp=5", cycle_cnt_o); end
    total++; if (stop_reason_o !== 2'd1) begin bad++; $display("FAIL count_stop got=%0d exp=1", stop_reason_o); end
    total++; if (r_words !== 12) begin bad++; $display("FAIL count_words got=%0d exp=12", r_words); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (r_idx[i] !== 5'(i) || r_data[i] !== regval(5'(i))) begin
        bad++; $display("FAIL count_word%0d got=%0d/%h exp=%0d/%h", i, r_idx[i], r_data[i], i, regval(5'(i)));
      end
    end
    total++; if (done_o !== 1'b1 || busy_o !== 1'b0 || cpu_en_o !== 1'b0) begin bad++; $display("FAIL count_done done/busy/en got=%0b/%0b/%0b exp=1/0/0", done_o, busy_o, cpu_en_o); end
    total++; if (cpu_rst_n_o !== 1'b1) begin bad++; $display("FAIL count_done_rst_n got=%0b exp=1", cpu_rst_n_o); end
  endtask

  task automatic test_halt();
    run_seq(100, 7, -1, 0, 0);
    total++; if (r_fin !== 1) begin bad++; $display("FAIL halt_timeout got=%0d exp=1", r_fin); end
    total++; if (r_en !== 7) begin bad++; $display("FAIL halt_en_cycles got=%0d exp=7", r_en); end
    total++; if (cycle_cnt_o !== 16'd7) begin bad++; $display("FAIL halt_cycle_cnt got=%0d exp=7", cycle_cnt_o); end
    total++; if (stop_reason_o !== 2'd2) begin bad++; $display("FAIL halt_stop got=%0d exp=2", stop_reason_o); end
    total++; if (r_words !== 12) begin bad++; $display("FAIL halt_words got=%0d exp=12", r_words); end
  endtask

  task automatic test_halt_on_last();
    run_seq(4, 4, -1, 0, 0);
    total++; if (r_early_cnt !== 0 || r_early_stop !== 0) begin bad++; $display("FAIL restart_clear cnt/stop got=%0d/%0d exp=0/0", r_early_cnt, r_early_stop); end
    total++; if (r_en !== 4) begin bad++; $display("FAIL tie_en_cycles got=%0d exp=4", r_en); end
    total++; if (cycle_cnt_o !== 16'd4) begin bad++; $display("FAIL tie_cycle_cnt got=%0d exp=4", cycle_cnt_o); end
    total++; if (stop_reason_o !== 2'd2) begin bad++; $display("FAIL tie_stop got=%0d exp=2", stop_reason_o); end
  endtask

  task automatic test_stall();
    run_seq(2, 0, 3, 10, 0);
    total++; if (r_fin !== 1) begin bad++; $display("FAIL stall_timeout got=%0d exp=1", r_fin); end
    total++; if (r_stall_valid !== 11) begin bad++; $display("FAIL stall_valid_cycles got=%0d exp=11", r_stall_valid); end
    total++; if (r_unstable !== 0) begin bad++; $display("FAIL stall_stable changes=%0d exp=0", r_unstable); end
    total++; if (r_words !== 12) begin bad++; $display("FAIL stall_words got=%0d exp=12", r_words); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (r_idx[i] !== 5'(i) || r_data[i] !== regval(5'(i))) begin
        bad++; $display("FAIL stall_word%0d got=%0d/%h exp=%0d/%h", i, r_idx[i], r_data[i], i, regval(5'(i)));
      end
    end
    total++; if (cycle_cnt_o !== 16'd2 || stop_reason_o !== 2'd1) begin bad++; $display("FAIL stall_cnt_stop got=%0d/%0d exp=2/1", cycle_cnt_o, stop_reason_o); end
  endtask

  task automatic test_zero_len();
    run_seq(0, 0, -1, 0, 1);
    total++; if (r_fin !== 1) begin bad++; $display("FAIL zero_timeout got=%0d exp=1", r_fin); end
    total++; if (r_en !== 0) begin bad++; $display("FAIL zero_en_cycles got=%0d exp=0", r_en); end
    total++; if (r_rstlow !== 1) begin bad++; $display("FAIL zero_rst_cycles got=%0d exp=1", r_rstlow); end
    total++; if (cycle_cnt_o !== 16'd0 || stop_reason_o !== 2'd1) begin bad++; $display("FAIL zero_cnt_stop got=%0d/%0d exp=0/1", cycle_cnt_o, stop_reason_o); end
    total++; if (r_words !== 12) begin bad++; $display("FAIL zero_words got=%0d exp=12", r_words); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (r_idx[i] !== 5'(i)) begin bad++; $display("FAIL zero_idx%0d got=%0d exp=%0d", i, r_idx[i], i); end
    end
  endtask

  task automatic test_abort_restart();
    bit found;
    found = 0;
    run_len_i = 16'd3;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (dump_if.dump_valid_o && dump_if.dump_idx_o == 5'd6) begin
        found = 1;
        break;
      end
      dump_if.dump_ready_i = dump_if.dump_valid_o;
      step();
    end
    dump_if.dump_ready_i = 1'b0;
    total++; if (found !== 1'b1) begin bad++; $display("FAIL abort_reach_word6 got=%0b exp=1", found); end
    #2 rst_i = 1'b0;
    #1;
    total++; if ({cpu_rst_n_o, cpu_en_o, dump_if.dump_valid_o, busy_o, done_o} !== 5'b0) begin bad++; $display("FAIL abort_flags got=%b exp=00000", {cpu_rst_n_o, cpu_en_o, dump_if.dump_valid_o, busy_o, done_o}); end
    total++; if (dump_if.dump_idx_o !== 5'd0 || dump_if.dump_data_o !== 32'd0 || dbg_addr_o !== 5'd0) begin bad++; $display("FAIL abort_dump got=%0d/%h/%0d exp=0/0/0", dump_if.dump_idx_o, dump_if.dump_data_o, dbg_addr_o); end
    total++; if (cycle_cnt_o !== 16'd0 || stop_reason_o !== 2'd0) begin bad++; $display("FAIL abort_cnt_stop got=%0d/%0d exp=0/0", cycle_cnt_o, stop_reason_o); end
    step(); step();
    rst_i = 1'b1;
    step();
    run_seq(2, 0, -1, 0, 0);
    total++; if (r_fin !== 1 || r_words !== 12) begin bad++; $display("FAIL fresh_words fin/words got=%0d/%0d exp=1/12", r_fin, r_words); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (r_idx[i] !== 5'(i) || r_data[i] !== regval(5'(i))) begin
        bad++; $display("FAIL fresh_word%0d got=%0d/%h exp=%0d/%h", i, r_idx[i], r_data[i], i, regval(5'(i)));
      end
    end
    total++; if (cycle_cnt_o !== 16'd2 || stop_reason_o !== 2'd1) begin bad++; $display("FAIL fresh_cnt_stop got=%0d/%0d exp=2/1", cycle_cnt_o, stop_reason_o); end
  endtask

  initial begin
    test_reset();
    test_count_run();
    test_halt();
    test_halt_on_last();
    test_stall();
    test_zero_len();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
